wb_user_bus_ctrl: RTL and testbench

//  Registered Wishbone transaction controller between the Caravel user-area slave port and the two user slaves.

---
 rtl/wb_ctrl_pkg.sv | 36 +++
 rtl/wb_timeout_cnt.sv | 26 ++
 rtl/wb_user_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_wb_user_bus_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ctrl_pkg.sv
// Shared types and address tags for the user-area Wishbone transaction controller.
// Holds the FSM/slave-select encodings and the address decode helper.
package wb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        SEL_S0,
        SEL_S1,
        SEL_ST,
        SEL_NONE
    } slv_sel_t;

    localparam logic [7:0]  S0_TAG_DEF   = 8'h38;
    localparam logic [11:0] S1_TAG_DEF   = 12'h301;
    localparam logic [11:0] ST_TAG_DEF   = 12'h302;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // S0 wins over S1, S1 over the status word; anything else is unmapped.
    function automatic slv_sel_t decode_adr(
        input logic [31:0] adr,
        input logic [7:0]  s0_tag,
        input logic [11:0] s1_tag,
        input logic [11:0] st_tag
    );
        if (adr[31:24] == s0_tag)      return SEL_S0;
        else if (adr[31:20] == s1_tag) return SEL_S1;
        else if (adr[31:20] == st_tag) return SEL_ST;
        else                           return SEL_NONE;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Slave-ack watchdog: counts REQ cycles; hit flags the last cycle before timeout.
// Clear has priority over enable; hit is combinational from the count.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 8'd0;
        else if (clr)
            cnt <= 8'd0;
        else if (en)
            cnt <= cnt + 8'd1;
    end

    assign hit = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/wb_user_bus_ctrl.sv
// Registered Wishbone controller: one outstanding cycle, decodes S0/S1/status, times out hung slaves.
// Master ack one cycle after slave ack (or after acceptance for status/unmapped); slave strobes held until ack.
module wb_user_bus_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [7:0]  S0_TAG   = S0_TAG_DEF,
    parameter logic [11:0] S1_TAG   = S1_TAG_DEF,
    parameter logic [11:0] ST_TAG   = ST_TAG_DEF,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        s0_stb_o,
    output logic        s0_cyc_o,
    output logic        s0_we_o,
    output logic [3:0]  s0_sel_o,
    output logic [31:0] s0_adr_o,
    output logic [31:0] s0_dat_o,
    input  logic        s0_ack_i,
    input  logic [31:0] s0_dat_i,
    output logic        s1_stb_o,
    output logic        s1_cyc_o,
    output logic        s1_we_o,
    output logic [3:0]  s1_sel_o,
    output logic [31:0] s1_adr_o,
    output logic [31:0] s1_dat_o,
    input  logic        s1_ack_i,
    input  logic [31:0] s1_dat_i,
    output logic        irq_o
);

    state_t      state, state_nxt;
    slv_sel_t    tgt_q, tgt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  bsel_q, bsel_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [19:0] err_adr_q, err_adr_d;
    logic        irq_q, irq_d;
    logic        hit;
    logic        slv_ack;
    logic [31:0] slv_dat;
    logic        s0_act, s1_act;

    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to_cnt (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_i),
        .clr   (state != REQ),
        .en    (state == REQ),
        .hit   (hit)
    );

    // Only the selected slave's ack counts; stray acks from the other one are ignored.
    assign slv_ack = (tgt_q == SEL_S0) ? s0_ack_i : s1_ack_i;
    assign slv_dat = (tgt_q == SEL_S0) ? s0_dat_i : s1_dat_i;

    always_comb begin
        state_nxt = state;
        tgt_d     = tgt_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        bsel_d    = bsel_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        to_cnt_d  = to_cnt_q;
        err_adr_d = err_adr_q;
        irq_d     = 1'b0;
        case (state)
            IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    adr_d  = wbs_adr_i;
                    wdat_d = wbs_dat_i;
                    bsel_d = wbs_sel_i;
                    we_d   = wbs_we_i;
                    tgt_d  = decode_adr(wbs_adr_i, S0_TAG, S1_TAG, ST_TAG);
                    case (tgt_d)
                        SEL_S0, SEL_S1: state_nxt = REQ;
                        SEL_ST: begin
                            rdata_d   = {to_cnt_q, 4'b0, err_adr_q};
                            state_nxt = RESP;
                        end
                        default: begin
                            rdata_d   = ERR_DATA;
                            err_adr_d = wbs_adr_i[19:0];
                            state_nxt = RESP;
                        end
                    endcase
                end
            end
            REQ: begin
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (slv_ack) begin
                    rdata_d   = slv_dat;
                    state_nxt = RESP;
                end else if (hit) begin
                    rdata_d   = ERR_DATA;
                    irq_d     = 1'b1;
                    to_cnt_d  = (to_cnt_q == 8'hFF) ? 8'hFF : to_cnt_q + 8'd1;
                    err_adr_d = adr_q[19:0];
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= IDLE;
            tgt_q     <= SEL_NONE;
            adr_q     <= 32'd0;
            wdat_q    <= 32'd0;
            bsel_q    <= 4'd0;
            we_q      <= 1'b0;
            rdata_q   <= 32'd0;
            to_cnt_q  <= 8'd0;
            err_adr_q <= 20'd0;
            irq_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            tgt_q     <= tgt_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            bsel_q    <= bsel_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            to_cnt_q  <= to_cnt_d;
            err_adr_q <= err_adr_d;
            irq_q     <= irq_d;
        end
    end

    // Slave ports are driven purely from registered state, so reset clears them at once.
    assign s0_act = (state == REQ) && (tgt_q == SEL_S0);
    assign s1_act = (state == REQ) && (tgt_q == SEL_S1);

    assign s0_stb_o = s0_act;
    assign s0_cyc_o = s0_act;
    assign s0_we_o  = s0_act & we_q;
    assign s0_sel_o = s0_act ? bsel_q : 4'd0;
    assign s0_adr_o = s0_act ? adr_q  : 32'd0;
    assign s0_dat_o = s0_act ? wdat_q : 32'd0;

    assign s1_stb_o = s1_act;
    assign s1_cyc_o = s1_act;
    assign s1_we_o  = s1_act & we_q;
    assign s1_sel_o = s1_act ? bsel_q : 4'd0;
    assign s1_adr_o = s1_act ? adr_q  : 32'd0;
    assign s1_dat_o = s1_act ? wdat_q : 32'd0;

    assign wbs_ack_o = (state == RESP);
    assign wbs_dat_o = (state == RESP) ? rdata_q : 32'd0;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_user_bus_ctrl.sv
// Directed bench for wb_user_bus_ctrl with a transaction-level model and a per-cycle compare process.
module tb_wb_user_bus_ctrl;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        s0_stb, s0_cyc, s0_we, s1_stb, s1_cyc, s1_we;
    logic [3:0]  s0_sel, s1_sel;
    logic [31:0] s0_adr, s0_wdat, s1_adr, s1_wdat;
    logic        s0_ack, s1_ack;
    logic [31:0] s0_rdat, s1_rdat;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // expected per-cycle outputs, written by the stimulus, checked on the falling edge
    logic        cmp_en = 1'b0;
    logic        exp_ack, exp_irq, exp_s0, exp_s1, chk_dat;
    logic [31:0] exp_dat, exp_adr, exp_wdat;
    logic [3:0]  exp_sel;
    logic        exp_we;

    // status model
    logic [7:0]  m_to  = 8'd0;
    logic [19:0] m_err = 20'd0;

    logic [31:0] got;

    always #5 clk = ~clk;

    wb_user_bus_ctrl #(.TIMEOUT(TO)) dut (
        .wb_clk_i (clk),     .wb_rst_i (rst_n),
        .wbs_stb_i(stb),     .wbs_cyc_i(cyc),     .wbs_we_i(we),
        .wbs_sel_i(sel),     .wbs_adr_i(adr),     .wbs_dat_i(wdat),
        .wbs_ack_o(ack),     .wbs_dat_o(rdat),
        .s0_stb_o (s0_stb),  .s0_cyc_o (s0_cyc),  .s0_we_o (s0_we),
        .s0_sel_o (s0_sel),  .s0_adr_o (s0_adr),  .s0_dat_o(s0_wdat),
        .s0_ack_i (s0_ack),  .s0_dat_i (s0_rdat),
        .s1_stb_o (s1_stb),  .s1_cyc_o (s1_cyc),  .s1_we_o (s1_we),
        .s1_sel_o (s1_sel),  .s1_adr_o (s1_adr),  .s1_dat_o(s1_wdat),
        .s1_ack_i (s1_ack),  .s1_dat_i (s1_rdat),
        .irq_o    (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk1("wbs_ack", ack, exp_ack);
            chk1("irq", irq, exp_irq);
            chk1("s0_stb", s0_stb, exp_s0);
            chk1("s0_cyc", s0_cyc, exp_s0);
            chk1("s1_stb", s1_stb, exp_s1);
            chk1("s1_cyc", s1_cyc, exp_s1);
            if (chk_dat) chk("wbs_dat", rdat, exp_dat);
            if (exp_s0) begin
                chk("s0_adr", s0_adr, exp_adr);
                chk("s0_dat", s0_wdat, exp_wdat);
                chk("s0_sel", {28'd0, s0_sel}, {28'd0, exp_sel});
                chk1("s0_we", s0_we, exp_we);
            end
            if (exp_s1) begin
                chk("s1_adr", s1_adr, exp_adr);
                chk("s1_dat", s1_wdat, exp_wdat);
                chk("s1_sel", {28'd0, s1_sel}, {28'd0, exp_sel});
                chk1("s1_we", s1_we, exp_we);
            end
        end
    end

    function automatic logic [31:0] st_word();
        return {m_to, 4'h0, m_err};
    endfunction

    function automatic int target(input logic [31:0] a);
        if (a[31:24] == 8'h38)       return 0;
        else if (a[31:20] == 12'h301) return 1;
        else if (a[31:20] == 12'h302) return 2;
        else                          return 3;
    endfunction

    task automatic set_idle_exp();
        exp_ack = 1'b0; exp_irq = 1'b0; exp_s0 = 1'b0; exp_s1 = 1'b0;
        chk_dat = 1'b1; exp_dat = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        stb = 1'b0; cyc = 1'b0; we = 1'b0; s0_ack = 1'b0; s1_ack = 1'b0;
        set_idle_exp();
        repeat (n) step();
    endtask

    // ack_at: REQ cycle index in which the slave acks (-1 = never); noise drives
    // acks from the non-selected slave and outside REQ, which must be ignored.
    task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [3:0] s, input int ack_at, input logic [31:0] sd,
                       input logic noise, output logic [31:0] resp_dat);
        int          tgt;
        logic        timed_out;
        logic [31:0] resp;
        tgt = target(a);
        stb = 1'b1; cyc = 1'b1; adr = a; wdat = d; we = w; sel = s;
        s0_ack = noise; s1_ack = noise; s0_rdat = sd; s1_rdat = sd;
        set_idle_exp();
        step();
        timed_out = 1'b0;
        resp = ERR;
        if (tgt < 2) begin
            for (int k = 0; k < TO; k++) begin
                exp_s0 = (tgt == 0); exp_s1 = (tgt == 1);
                exp_adr = a; exp_wdat = d; exp_sel = s; exp_we = w;
                s0_ack = (tgt == 0) ? (k == ack_at) : noise;
                s1_ack = (tgt == 1) ? (k == ack_at) : noise;
                step();
                if (k == ack_at) break;
                if (k == TO - 1) timed_out = 1'b1;
            end
            resp = timed_out ? ERR : sd;
            if (timed_out) begin
                m_to  = (m_to == 8'hFF) ? 8'hFF : m_to + 8'd1;
                m_err = a[19:0];
            end
        end else if (tgt == 2) begin
            resp = st_word();
        end else begin
            m_err = a[19:0];
        end
        s0_ack = noise; s1_ack = noise;
        exp_s0 = 1'b0; exp_s1 = 1'b0;
        exp_ack = 1'b1; exp_irq = timed_out; chk_dat = !w; exp_dat = resp;
        resp_dat = rdat;
        step();
        s0_ack = 1'b0; s1_ack = 1'b0;
        set_idle_exp();
    endtask

    // Master drops cyc in REQ cycle index 'at'; strobes fall on the next edge, no ack.
    task automatic abort_s0(input logic [31:0] a, input int at);
        stb = 1'b1; cyc = 1'b1; adr = a; wdat = 32'h0; we = 1'b0; sel = 4'hF;
        set_idle_exp();
        step();
        for (int k = 0; k <= at; k++) begin
            exp_s0 = 1'b1; exp_adr = a; exp_wdat = 32'h0; exp_sel = 4'hF; exp_we = 1'b0;
            if (k == at) begin
                stb = 1'b0; cyc = 1'b0;
            end
            step();
        end
        idle(3);
    endtask

    initial begin
        rst_n = 1'b0;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        s0_ack = 1'b0; s1_ack = 1'b0; s0_rdat = 32'h0; s1_rdat = 32'h0;
        set_idle_exp();
        exp_adr = 32'h0; exp_wdat = 32'h0; exp_sel = 4'h0; exp_we = 1'b0;
        step();
        chk1("rst_ack", ack, 1'b0);
        chk("rst_dat", rdat, 32'h0);
        chk1("rst_s0_stb", s0_stb, 1'b0);
        chk1("rst_s1_stb", s1_stb, 1'b0);
        chk1("rst_irq", irq, 1'b0);
        cmp_en = 1'b1;
        step();
        rst_n = 1'b1;
        idle(2);

        txn(32'h3800_0010, 32'h0, 1'b0, 4'hF, 3, 32'h1234_5678, 1'b0, got);
        chk("s0_read", got, 32'h1234_5678);
        idle(1);
        txn(32'h3010_0004, 32'hA5A5_0001, 1'b1, 4'hF, 2, 32'h0, 1'b0, got);
        idle(1);
        txn(32'h4000_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("unmapped_read", got, 32'hDEAD_BEEF);
        txn(32'h3020_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("status_after_unmapped", got, 32'h0000_0000);
        txn(32'h3800_0010, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("timeout_read", got, 32'hDEAD_BEEF);
        txn(32'h3020_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("status_after_timeout", got, 32'h0100_0010);

        // ack on the timeout cycle completes normally; stray acks are ignored
        txn(32'h3010_0020, 32'h0, 1'b0, 4'h3, TO - 1, 32'hCAFE_0007, 1'b1, got);
        chk("ack_at_timeout", got, 32'hCAFE_0007);
        txn(32'h38AB_CDEF, 32'h1111_2222, 1'b1, 4'h5, 0, 32'h0, 1'b1, got);

        abort_s0(32'h3800_0044, 1);
        txn(32'h3800_0048, 32'h0, 1'b0, 4'hF, 1, 32'h0BAD_F00D, 1'b0, got);
        chk("after_abort", got, 32'h0BAD_F00D);
        abort_s0(32'h3800_0050, TO - 2);
        txn(32'h3800_0010, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        txn(32'h3020_0000, 32'hFFFF_FFFF, 1'b1, 4'hF, -1, 32'h0, 1'b0, got);
        txn(32'h3020_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("status_two_timeouts", got, 32'h0200_0010);
        txn(32'h5000_1234, 32'h7777_7777, 1'b1, 4'hF, -1, 32'h0, 1'b0, got);
        txn(32'h3020_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("status_unmapped_write", got, 32'h0200_1234);

        for (int i = 0; i < 256; i++)
            txn(32'h3800_0ABC, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        txn(32'h3020_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("status_saturated", got, 32'hFF00_0ABC);
        idle(1);

        // asynchronous reset in the middle of a slave request
        stb = 1'b1; cyc = 1'b1; adr = 32'h3800_0100; we = 1'b0; sel = 4'hF;
        step();
        exp_s0 = 1'b1; exp_adr = 32'h3800_0100; exp_wdat = wdat; exp_sel = 4'hF; exp_we = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        stb = 1'b0; cyc = 1'b0;
        set_idle_exp();
        m_to = 8'd0; m_err = 20'd0;
        #1;
        chk1("arst_s0_stb", s0_stb, 1'b0);
        chk1("arst_s0_cyc", s0_cyc, 1'b0);
        chk1("arst_ack", ack, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        idle(2);
        txn(32'h3020_0000, 32'h0, 1'b0, 4'hF, -1, 32'h0, 1'b0, got);
        chk("status_after_reset", got, 32'h0000_0000);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
